// File: rtl/resp_packetizer_if.sv
// Handshake bundle for resp_packetizer: 128-bit response in, framed bytes out.
// The master modport is the packetizer's view; slave is the surrounding logic.
interface resp_packetizer_if;
   logic         resp_valid;
   logic [127:0] resp_data;
   logic         resp_ready;
   logic [7:0]   byte_data;
   logic         byte_valid;
   logic         byte_ready;

   modport master (
      input  resp_valid, resp_data, byte_ready,
      output resp_ready, byte_data, byte_valid
   );

   modport slave (
      output resp_valid, resp_data, byte_ready,
      input  resp_ready, byte_data, byte_valid
   );
endinterface

// File: rtl/resp_packetizer.sv
// Frames a captured 128-bit PUF response as SYNC + 16 data bytes + XOR checksum
// for a byte-wide UART transmitter.
module resp_packetizer #(
   parameter logic [7:0] SYNC_BYTE = 8'hA5,
   parameter bit         MSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   resp_packetizer_if.master bus,
   output logic              busy,
   output logic              pkt_done,
   output logic [15:0]       pkt_count
);
   typedef enum logic [2:0] {IDLE, SYNC, DATA, CSUM, DONE} state_t;

   state_t       r_state;
   logic [127:0] r_shadow;
   logic [3:0]   r_index;
   logic [7:0]   r_csum;
   logic [7:0]   r_byte_data;
   logic         r_byte_valid;
   logic         r_resp_ready;
   logic         r_busy;
   logic         r_pkt_done;
   logic [15:0]  r_pkt_count;

   logic         w_xfer;
   logic [7:0]   w_csum_next;

   // Byte number idx of the shadow word in transmit order (15 - idx == ~idx).
   function automatic logic [7:0] sel_byte(input logic [127:0] word, input logic [3:0] idx);
      logic [3:0] pos;
      pos = MSB_FIRST ? ~idx : idx;
      return word[{pos, 3'b000} +: 8];
   endfunction

   assign w_xfer      = r_byte_valid & bus.byte_ready;
   assign w_csum_next = r_csum ^ r_byte_data;

   // NOTE: every output below is a register updated with <=, so the next byte is
   // prepared on the same edge that retires the current one.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_shadow     <= '0;
         r_index      <= '0;
         r_csum       <= '0;
         r_byte_data  <= '0;
         r_byte_valid <= 1'b0;
         r_resp_ready <= 1'b1;
         r_busy       <= 1'b0;
         r_pkt_done   <= 1'b0;
         r_pkt_count  <= '0;
      end else begin
         r_pkt_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.resp_valid) begin
                  r_shadow     <= bus.resp_data;
                  r_state      <= SYNC;
                  r_byte_data  <= SYNC_BYTE;
                  r_byte_valid <= 1'b1;
                  r_resp_ready <= 1'b0;
                  r_busy       <= 1'b1;
                  r_index      <= '0;
                  r_csum       <= '0;
               end
            end
            SYNC: begin
               if (w_xfer) begin
                  r_state     <= DATA;
                  r_index     <= '0;
                  r_byte_data <= sel_byte(r_shadow, 4'd0);
               end
            end
            DATA: begin
               if (w_xfer) begin
                  r_csum  <= w_csum_next;
                  r_index <= r_index + 4'd1;
                  if (r_index == 4'd15) begin
                     r_state     <= CSUM;
                     r_byte_data <= w_csum_next;
                  end else begin
                     r_byte_data <= sel_byte(r_shadow, r_index + 4'd1);
                  end
               end
            end
            CSUM: begin
               if (w_xfer) begin
                  r_state      <= DONE;
                  r_byte_valid <= 1'b0;
                  r_byte_data  <= '0;
                  r_pkt_done   <= 1'b1;
               end
            end
            DONE: begin
               r_state      <= IDLE;
               r_resp_ready <= 1'b1;
               r_busy       <= 1'b0;
               r_pkt_count  <= r_pkt_count + 16'd1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.resp_ready = r_resp_ready;
   assign bus.byte_data  = r_byte_data;
   assign bus.byte_valid = r_byte_valid;
   assign busy           = r_busy;
   assign pkt_done       = r_pkt_done;
   assign pkt_count      = r_pkt_count;
endmodule

// File: doc/resp_packetizer.md
RESP_PACKETIZER -- requirements
Module: resp_packetizer

Interface
REQ-001 The block SHALL have parameter SYNC_BYTE, default 8'hA5, the packet header byte.
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 = response byte [127:120] sent first; 0 = byte [7:0] sent first.
REQ-003 The block SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port resp_valid  input  1  a 128-bit PUF response is offered.
REQ-006 The block SHALL have port resp_data  input  128  response word; sampled only on capture.
REQ-007 The block SHALL have port resp_ready  output  1  block can capture a response.
REQ-008 The block SHALL have port byte_data  output  8  byte offered to the downstream byte-UART transmitter.
REQ-009 The block SHALL have port byte_valid  output  1  byte_data is valid.
REQ-010 The block SHALL have port byte_ready  input  1  transmitter accepts byte_data this cycle.
REQ-011 The block SHALL have port busy  output  1  packet in progress.
REQ-012 The block SHALL have port pkt_done  output  1  one-cycle pulse after the checksum byte transfers.
REQ-013 The block SHALL have port pkt_count  output  16  number of completed packets.

Function
REQ-014 FSM states SHALL be IDLE, SYNC, DATA, CSUM and DONE.
REQ-015 Capture SHALL occur on a rising edge with resp_valid=1 and resp_ready=1; resp_data is latched into a 128-bit shadow register; FSM goes IDLE->SYNC.
REQ-016 resp_ready SHALL be 1 only in IDLE; resp_valid in any other state is ignored, and the shadow register is not modified.
REQ-017 A byte transfer SHALL occur on a rising edge with byte_valid=1 and byte_ready=1.
REQ-018 byte_valid SHALL be 1 in SYNC, DATA and CSUM, and 0 in IDLE and DONE.
REQ-019 While byte_valid=1 and byte_ready=0, byte_data SHALL hold constant and the FSM SHALL not advance.
REQ-020 In SYNC, byte_data SHALL equal SYNC_BYTE; a transfer moves the FSM to DATA with the 4-bit byte index at 0.
REQ-021 In DATA, byte_data SHALL be shadow byte number index, ordered per MSB_FIRST; each transfer increments index; a transfer at index 15 moves the FSM to CSUM (index wraps to 0).
REQ-022 In CSUM, byte_data SHALL equal the XOR of the 16 data bytes (SYNC excluded), accumulated as data bytes transfer.
REQ-023 A CSUM transfer SHALL move the FSM to DONE.
REQ-024 DONE SHALL last exactly one cycle, then return to IDLE; pkt_done=1 only in DONE.
REQ-025 pkt_count SHALL increment by 1 in DONE and wrap 16'hFFFF->0.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 Latency: capture at edge N gives byte_valid=1 with SYNC_BYTE in cycle N+1; with byte_ready held 1, pkt_done is high in cycle N+19, and resp_ready=1 again in cycle N+20.
REQ-028 A packet SHALL always be exactly 18 bytes: SYNC, 16 data bytes, CSUM.

Reset
REQ-029 When rst=1 at a rising edge, the block SHALL enter IDLE with byte_valid=0, busy=0, pkt_done=0, byte_data=8'h00, pkt_count=0, index=0, checksum=0 and shadow=0.
REQ-030 rst SHALL take priority over capture and transfer in the same cycle.
REQ-031 Reset mid-packet SHALL abort the packet: no further bytes, no pkt_done, and pkt_count cleared.
REQ-032 resp_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-033 Default params, byte_ready=1, resp_data=128'hABCDEF9876543210ABCDEF9876543210 -> bytes A5,AB,CD,EF,98,76,54,32,10,AB,CD,EF,98,76,54,32,10,00; one pkt_done; pkt_count=1.
REQ-034 MSB_FIRST=0, resp_data=128'h000000000000000000000000000000F1 -> bytes A5,F1,00 x15,F1.
REQ-035 byte_ready=0 for 5 cycles while data byte 3 (EF) is offered -> byte_data stays EF and byte_valid stays 1 throughout; the packet then completes unchanged.
REQ-036 resp_valid pulsed with 128'h1 while busy -> no capture; the current packet's bytes and checksum are unchanged; the next capture is accepted only after DONE.
REQ-037 rst asserted after the 6th byte transfer -> byte_valid=0 next cycle, no pkt_done, pkt_count=0; a new response then produces a complete 18-byte packet.
REQ-038 Back-to-back: resp_valid held 1 with byte_ready=1 -> capture every 20 cycles, and pkt_count counts 1,2,3.
